// File: rtl/note_pkg.sv
// Shared types and the period threshold table for the note classifier.
package note_pkg;

    localparam int N_NOTES         = 24;
    localparam int MIC_SAMPLE_RATE = 48835;

    typedef logic [4:0] note_idx_t;

    localparam note_idx_t NOTE_NONE = 5'h1F;

    // Upper period bound (in mic samples) of each semitone bin, C3 first.
    // Entry i is floor(48835 / (f_i * 2^(-1/24))), i.e. the period at the
    // quarter-tone below note i. Entry 24 closes the top of B4.
    localparam logic [8:0] NOTE_PERIOD_HI [0:24] = '{
        9'd384, 9'd362, 9'd342, 9'd323, 9'd304, 9'd287, 9'd271, 9'd256,
        9'd242, 9'd228, 9'd215, 9'd203, 9'd192, 9'd181, 9'd171, 9'd161,
        9'd152, 9'd143, 9'd135, 9'd128, 9'd121, 9'd114, 9'd107, 9'd101,
        9'd96
    };

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } srch_state_t;

endpackage

// File: rtl/note_stabilizer.sv
// Debounces raw classifier results into a held note and forces silence when
// the period meter goes quiet for too many mic samples.
module note_stabilizer
    import note_pkg::*;
#(
    parameter int STABLE_CNT      = 3,
    parameter int TIMEOUT_SAMPLES = 4096
) (
    input  logic      clk,
    input  logic      reset_p,
    input  note_idx_t raw_idx,
    input  logic      raw_valid,
    input  logic      tmo_clr,
    input  logic      mic_we,
    output note_idx_t note_idx,
    output logic      note_valid,
    output logic      note_change
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int TW = $clog2(TIMEOUT_SAMPLES + 1);

    note_idx_t       cand_q, cand_nxt;
    note_idx_t       note_q, note_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic [TW-1:0]   tmo_q;
    logic            tmo_hit;

    // The terminal mic sample only times out if no period is being accepted.
    always_comb begin
        tmo_hit = mic_we && !tmo_clr && (tmo_q == TW'(TIMEOUT_SAMPLES - 1));
    end

    // Filter next state; timeout overrides a coincident raw result.
    always_comb begin
        cand_nxt = cand_q;
        cnt_nxt  = cnt_q;
        note_nxt = note_q;
        if (tmo_hit) begin
            cand_nxt = NOTE_NONE;
            cnt_nxt  = '0;
            note_nxt = NOTE_NONE;
        end else if (raw_valid) begin
            if (raw_idx == cand_q) begin
                if (cnt_q != CW'(STABLE_CNT))
                    cnt_nxt = cnt_q + CW'(1);
            end else begin
                cand_nxt = raw_idx;
                cnt_nxt  = CW'(1);
            end
            if (cnt_nxt == CW'(STABLE_CNT) && cand_nxt != note_q)
                note_nxt = cand_nxt;
        end
    end

    // Filter registers and the change strobe.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            cand_q      <= NOTE_NONE;
            cnt_q       <= '0;
            note_q      <= NOTE_NONE;
            note_change <= 1'b0;
        end else begin
            cand_q      <= cand_nxt;
            cnt_q       <= cnt_nxt;
            note_q      <= note_nxt;
            note_change <= (note_nxt != note_q);
        end
    end

    // Mic-sample timeout counter, saturating so the timeout fires once.
    always_ff @(posedge clk) begin
        if (reset_p)
            tmo_q <= '0;
        else if (tmo_clr)
            tmo_q <= '0;
        else if (mic_we && tmo_q != TW'(TIMEOUT_SAMPLES))
            tmo_q <= tmo_q + TW'(1);
    end

    assign note_idx   = note_q;
    assign note_valid = (note_q != NOTE_NONE);

endmodule

// File: rtl/note_period_classifier.sv
// Maps zero-crossing periods to semitone indices C3..B4 with a sequential
// table search, then hands results to the stabilizer.
module note_period_classifier
    import note_pkg::*;
#(
    parameter int W_PERIOD        = 16,
    parameter int STABLE_CNT      = 3,
    parameter int TIMEOUT_SAMPLES = 4096
) (
    input  logic                clk,
    input  logic                reset_p,
    input  logic [W_PERIOD-1:0] period,
    input  logic                period_valid,
    input  logic                mic_we,
    output logic                busy,
    output logic                overrun,
    output logic [4:0]          raw_idx,
    output logic                raw_valid,
    output logic [4:0]          note_idx,
    output logic                note_valid,
    output logic                note_change
);

    srch_state_t         state, state_nxt;
    logic [W_PERIOD-1:0] per_q;
    logic [4:0]          k_q;
    logic [W_PERIOD-1:0] hi_k;
    logic                accept;
    logic                done;
    logic                k_inc;
    note_idx_t           result;

    assign busy   = (state == ST_SEARCH);
    assign accept = (state == ST_IDLE) && period_valid;
    assign hi_k   = W_PERIOD'(NOTE_PERIOD_HI[k_q]);

    // State register.
    always_ff @(posedge clk) begin
        if (reset_p)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state and search decision: one threshold compare per cycle.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        k_inc     = 1'b0;
        result    = NOTE_NONE;
        case (state)
            ST_IDLE: begin
                if (period_valid)
                    state_nxt = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (per_q > hi_k) begin
                    done      = 1'b1;
                    result    = (k_q == 5'd0) ? NOTE_NONE : (k_q - 5'd1);
                    state_nxt = ST_IDLE;
                end else if (k_q == 5'(N_NOTES)) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    k_inc = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Period latch, index counter, raw result and overrun flag.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            per_q     <= '0;
            k_q       <= '0;
            raw_idx   <= NOTE_NONE;
            raw_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            raw_valid <= done;
            overrun   <= period_valid && busy;
            if (accept) begin
                per_q <= period;
                k_q   <= '0;
            end else if (k_inc) begin
                k_q <= k_q + 5'd1;
            end
            if (done)
                raw_idx <= result;
        end
    end

    note_stabilizer #(
        .STABLE_CNT      (STABLE_CNT),
        .TIMEOUT_SAMPLES (TIMEOUT_SAMPLES)
    ) u_stab (
        .clk         (clk),
        .reset_p     (reset_p),
        .raw_idx     (raw_idx),
        .raw_valid   (raw_valid),
        .tmo_clr     (accept),
        .mic_we      (mic_we),
        .note_idx    (note_idx),
        .note_valid  (note_valid),
        .note_change (note_change)
    );

endmodule
